// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl_pkg: shared types and constants for the timer controller.
// The optional prescaler is enabled by defining TIMER_CTRL_PRESCALE_EN.
package timer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Register map
  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_COMPARE  = 2'd1;
  localparam logic [1:0] ADDR_PRESCALE = 2'd2;
  localparam logic [1:0] ADDR_STATUS   = 2'd3;

  // CTRL bit positions (start/stop are write-only strobes)
  localparam int CTRL_START_BIT    = 0;
  localparam int CTRL_PERIODIC_BIT = 1;
  localparam int CTRL_IRQ_EN_BIT   = 2;
  localparam int CTRL_STOP_BIT     = 3;
  localparam int CTRL_STATE_LSB    = 4;

  // STATUS bit positions
  localparam int STATUS_EXPIRED_BIT = 0;

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides the run-time clock by (reload+1), emitting a
// one-cycle tick. Held at zero whenever enable is low so every run starts
// with a full prescale period.
module timer_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic [PRESCALE_W-1:0] reload_i,
  output logic                  tick_o
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  // A reload lowered below the running count fires at once instead of
  // waiting for the counter to wrap.
  assign tick_o = en_i && (cnt_q >= reload_i);

  // Next prescale count: clear on tick or when disabled, else increment.
  always_comb begin
    cnt_d = '0;
    if (en_i && !tick_o) begin
      cnt_d = cnt_q + PRESCALE_W'(1);
    end
  end

  // Prescale counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: memory-mapped programmable timer with one-shot and periodic
// modes and a level interrupt on expiry.
// Define TIMER_CTRL_PRESCALE_EN to build the PRESCALE register and the
// clock prescaler; otherwise the counter advances every RUN cycle.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int PRESCALE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [WIDTH-1:0] cfg_wdata,
  output logic [WIDTH-1:0] cfg_rdata,
  output logic [WIDTH-1:0] count,
  output logic             irq,
  output logic             busy
);

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      count_q, count_d;
  logic [WIDTH-1:0]      compare_q;
  logic                  periodic_q;
  logic                  irq_en_q;
  logic                  expired_q, expired_d;
  logic [PRESCALE_W-1:0] prescale_val;
  logic [WIDTH-1:0]      prescale_rd;
  logic                  tick;

  logic ctrl_wr, start, stop, status_clr;

  assign ctrl_wr    = cfg_we && (cfg_addr == ADDR_CTRL);
  assign start      = ctrl_wr && cfg_wdata[CTRL_START_BIT];
  assign stop       = ctrl_wr && cfg_wdata[CTRL_STOP_BIT];
  assign status_clr = cfg_we && (cfg_addr == ADDR_STATUS) && cfg_wdata[STATUS_EXPIRED_BIT];

`ifdef TIMER_CTRL_PRESCALE_EN
  logic [PRESCALE_W-1:0] prescale_q;

  // PRESCALE register write.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescale_q <= '0;
    end else if (cfg_we && (cfg_addr == ADDR_PRESCALE)) begin
      prescale_q <= cfg_wdata[PRESCALE_W-1:0];
    end
  end

  assign prescale_val = prescale_q;

  // Disabled on start/stop edges so a restart begins with a cleared prescaler.
  timer_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .en_i    ((state_q == ST_RUN) && !start && !stop),
    .reload_i(prescale_q),
    .tick_o  (tick)
  );
`else
  assign prescale_val = '0;
  assign tick         = (state_q == ST_RUN);
`endif

  // Zero-extend the prescale value for readback.
  always_comb begin
    prescale_rd                   = '0;
    prescale_rd[PRESCALE_W-1:0]   = prescale_val;
  end

  // CTRL mode bits and COMPARE register writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      periodic_q <= 1'b0;
      irq_en_q   <= 1'b0;
      compare_q  <= '0;
    end else if (cfg_we) begin
      if (cfg_addr == ADDR_CTRL) begin
        periodic_q <= cfg_wdata[CTRL_PERIODIC_BIT];
        irq_en_q   <= cfg_wdata[CTRL_IRQ_EN_BIT];
      end
      if (cfg_addr == ADDR_COMPARE) begin
        compare_q <= cfg_wdata;
      end
    end
  end

  // Next state, counter and expiry: stop beats start, start beats ticking,
  // and an expiry set beats a same-cycle STATUS clear.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    expired_d = expired_q;
    if (status_clr) begin
      expired_d = 1'b0;
    end
    if (stop) begin
      state_d = ST_IDLE;
    end else if (start) begin
      state_d = ST_RUN;
      count_d = '0;
    end else if ((state_q == ST_RUN) && tick) begin
      if (count_q == compare_q) begin
        expired_d = 1'b1;
        if (periodic_q) begin
          count_d = '0;
        end else begin
          state_d = ST_DONE;
        end
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  // State, counter and expiry registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

  // Combinational register readback.
  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_CTRL: begin
        cfg_rdata[CTRL_PERIODIC_BIT]        = periodic_q;
        cfg_rdata[CTRL_IRQ_EN_BIT]          = irq_en_q;
        cfg_rdata[CTRL_STATE_LSB +: 2]      = state_q;
      end
      ADDR_COMPARE:  cfg_rdata = compare_q;
      ADDR_PRESCALE: cfg_rdata = prescale_rd;
      default:       cfg_rdata[STATUS_EXPIRED_BIT] = expired_q;
    endcase
  end

  assign count = count_q;
  assign busy  = (state_q == ST_RUN);
  assign irq   = expired_q && irq_en_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: table-driven register checks plus scripted timer sequences.
// Expected prescale behaviour follows TIMER_CTRL_PRESCALE_EN.
module tb_timer_ctrl;
  import timer_ctrl_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cfg_we = 1'b0;
  logic [1:0]   cfg_addr = 2'd0;
  logic [W-1:0] cfg_wdata = '0;
  logic [W-1:0] cfg_rdata;
  logic [W-1:0] count;
  logic         irq;
  logic         busy;

  int errors = 0;
  int checks = 0;

  timer_ctrl #(.WIDTH(W), .PRESCALE_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata),
    .count    (count),
    .irq      (irq),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         we;
    logic [1:0]   addr;
    logic [W-1:0] wdata;
    logic [1:0]   rd_addr;
    logic [W-1:0] exp_rd;
    string        name;
  } vec_t;

  typedef struct {
    string        name;
    logic [W-1:0] cnt;
    logic         bsy;
    logic         irq;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];

`ifdef TIMER_CTRL_PRESCALE_EN
  localparam bit PS_ON = 1'b1;
`else
  localparam bit PS_ON = 1'b0;
`endif

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // One clock cycle with the given register access; outputs settle 1ns later.
  task automatic step(input logic we, input logic [1:0] addr, input logic [W-1:0] data);
    @(negedge clk);
    cfg_we    = we;
    cfg_addr  = addr;
    cfg_wdata = data;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, ADDR_STATUS, '0);
  endtask

  task automatic expect_out(input string name, input logic [W-1:0] cnt, input logic bsy, input logic ir);
    exp_t e;
    e.name = name; e.cnt = cnt; e.bsy = bsy; e.irq = ir;
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.name, "_count"}, count, e.cnt);
      chk({e.name, "_busy"}, W'(busy), W'(e.bsy));
      chk({e.name, "_irq"}, W'(irq), W'(e.irq));
    end
  endtask

  task automatic rd_chk(input string name, input logic [1:0] addr, input logic [W-1:0] exp);
    cfg_addr = addr;
    #1;
    chk(name, cfg_rdata, exp);
  endtask

  initial begin
    logic [W-1:0] ps_exp;
    ps_exp = PS_ON ? W'(8'h5A) : '0;
    vecs[0] = '{1'b1, ADDR_COMPARE,  8'hA5, ADDR_COMPARE,  8'hA5, "cmp_rw"};
    vecs[1] = '{1'b1, ADDR_PRESCALE, 8'h5A, ADDR_PRESCALE, ps_exp, "ps_rw"};
    vecs[2] = '{1'b1, ADDR_CTRL,     8'h06, ADDR_CTRL,     8'h06, "ctrl_rw6"};
    vecs[3] = '{1'b1, ADDR_CTRL,     8'h02, ADDR_CTRL,     8'h02, "ctrl_rw2"};
    vecs[4] = '{1'b1, ADDR_STATUS,   8'h01, ADDR_STATUS,   8'h00, "status_w1"};
    vecs[5] = '{1'b0, ADDR_CTRL,     8'hFF, ADDR_COMPARE,  8'hA5, "cmp_hold"};
    vecs[6] = '{1'b1, ADDR_COMPARE,  8'h00, ADDR_COMPARE,  8'h00, "cmp_zero"};
    vecs[7] = '{1'b1, ADDR_PRESCALE, 8'h00, ADDR_PRESCALE, 8'h00, "ps_zero"};
    vecs[8] = '{1'b1, ADDR_CTRL,     8'h00, ADDR_CTRL,     8'h00, "ctrl_zero"};

    // Reset held for two cycles
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 0, 0, 0);
    check_sb();
    rd_chk("reset_ctrl", ADDR_CTRL, 0);
    rd_chk("reset_cmp", ADDR_COMPARE, 0);
    rd_chk("reset_ps", ADDR_PRESCALE, 0);
    rst = 1'b0;

    // Register read/write table
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      rd_chk(vecs[i].name, vecs[i].rd_addr, vecs[i].exp_rd);
    end

    // One-shot, COMPARE=9, irq enabled
    step(1'b1, ADDR_COMPARE, 8'd9);
    expect_out("os_start", 0, 1, 0);
    step(1'b1, ADDR_CTRL, 8'h05);
    check_sb();
    rd_chk("os_ctrl_run", ADDR_CTRL, 8'h14);
    for (int k = 1; k <= 9; k++) begin
      expect_out($sformatf("os_k%0d", k), W'(k), 1, 0);
      idle(1);
      check_sb();
    end
    expect_out("os_done", 9, 0, 1);
    idle(1);
    check_sb();
    rd_chk("os_ctrl_done", ADDR_CTRL, 8'h24);
    rd_chk("os_status", ADDR_STATUS, 8'h01);
    idle(20);
    expect_out("os_hold", 9, 0, 1);
    check_sb();
    expect_out("os_clear", 9, 0, 0);
    step(1'b1, ADDR_STATUS, 8'h01);
    check_sb();

    // Periodic, COMPARE=4; STATUS clears at k=6, k=15 (match edge), k=16
    step(1'b1, ADDR_COMPARE, 8'd4);
    expect_out("per_start", 0, 1, 0);
    step(1'b1, ADDR_CTRL, 8'h03);
    check_sb();
    for (int k = 1; k <= 16; k++) begin
      logic wr;
      logic exp_x;
      wr    = (k == 6) || (k == 15) || (k == 16);
      exp_x = (k == 5) || (k >= 10 && k <= 15);
      expect_out($sformatf("per_k%0d", k), W'(k % 5), 1, 0);
      step(wr, ADDR_STATUS, 8'h01);
      check_sb();
      rd_chk($sformatf("per_exp_k%0d", k), ADDR_STATUS, W'(exp_x));
    end

    // Stop at count 7, then start+stop together
    step(1'b1, ADDR_COMPARE, 8'd100);
    step(1'b1, ADDR_CTRL, 8'h01);
    idle(7);
    expect_out("pre_stop", 7, 1, 0);
    check_sb();
    expect_out("stop", 7, 0, 0);
    step(1'b1, ADDR_CTRL, 8'h08);
    check_sb();
    idle(3);
    expect_out("stop_hold", 7, 0, 0);
    check_sb();
    rd_chk("stop_ctrl", ADDR_CTRL, 8'h00);
    expect_out("start_stop", 7, 0, 0);
    step(1'b1, ADDR_CTRL, 8'h09);
    check_sb();
    idle(2);
    expect_out("start_stop_hold", 7, 0, 0);
    check_sb();

    // COMPARE lowered below count: wrap through 255 -> 0, then match at 5
    step(1'b1, ADDR_COMPARE, 8'd20);
    step(1'b1, ADDR_CTRL, 8'h01);
    idle(10);
    expect_out("wrap_pre", 10, 1, 0);
    check_sb();
    step(1'b1, ADDR_COMPARE, 8'd5);
    idle(244);
    expect_out("wrap_max", 8'hFF, 1, 0);
    check_sb();
    expect_out("wrap_zero", 0, 1, 0);
    idle(1);
    check_sb();
    idle(5);
    expect_out("wrap_five", 5, 1, 0);
    check_sb();
    rd_chk("wrap_not_expired", ADDR_STATUS, 8'h00);
    expect_out("wrap_match", 5, 0, 0);
    idle(1);
    check_sb();
    rd_chk("wrap_expired", ADDR_STATUS, 8'h01);

    // Prescale 2, COMPARE all ones, 30 cycles
    step(1'b1, ADDR_STATUS, 8'h01);
    step(1'b1, ADDR_PRESCALE, 8'd2);
    step(1'b1, ADDR_COMPARE, 8'hFF);
    step(1'b1, ADDR_CTRL, 8'h01);
    idle(30);
    expect_out("prescale", PS_ON ? W'(10) : W'(30), 1, 0);
    check_sb();
    rd_chk("prescale_rd", ADDR_PRESCALE, PS_ON ? W'(2) : W'(0));

    // Reset mid-run with irq asserted
    step(1'b1, ADDR_COMPARE, 8'd3);
    step(1'b1, ADDR_CTRL, 8'h07);
    idle(15);
    expect_out("pre_rst", count, 1, 1);
    sb.pop_back();
    chk("pre_rst_irq", W'(irq), W'(1));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_out("mid_rst", 0, 0, 0);
    check_sb();
    rd_chk("mid_rst_ctrl", ADDR_CTRL, 0);
    rd_chk("mid_rst_cmp", ADDR_COMPARE, 0);
    rd_chk("mid_rst_status", ADDR_STATUS, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
